nw_path_decoder: RTL and testbench

- Consumer end of the Needleman-Wunsch traceback stream: accepts {x,y} coordinate words emitted by the grid traceback, in order from (LENGTH-1,LENGTH-1) to (0,0).
- Classifies each step, buffers the columns in a LIFO and replays them in forward order as alignment columns (s1 char, s2 char, gap flags).
- Sits between the traceback memory/FIFO read port and downstream alignment output logic.

---
 rtl/nw_path_decoder_if.sv | 29 ++
 rtl/nw_path_decoder.sv | 219 +++++++++++++++++++++
 tb/tb_nw_path_decoder.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/nw_path_decoder_if.sv
// Stream bundle for nw_path_decoder: traceback coordinate input and
// alignment column output, each with a valid/ready handshake.
interface nw_path_decoder_if #(
   parameter int CWIDTH      = 2,
   parameter int CORD_LENGTH = 8
);
   logic                     in_valid;
   logic                     in_ready;
   logic [2*CORD_LENGTH-1:0] in_data;
   logic                     out_valid;
   logic                     out_ready;
   logic [1:0]               out_op;
   logic [CWIDTH-1:0]        out_c1;
   logic [CWIDTH-1:0]        out_c2;
   logic                     out_match;
   logic                     out_last;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_op, out_c1, out_c2,
      output out_match, out_last
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_op, out_c1, out_c2,
      input  out_match, out_last
   );
endinterface

// File: rtl/nw_path_decoder.sv
// Needleman-Wunsch traceback consumer: stacks path steps, replays them forward.
// Optional running alignment score enabled by defining NW_DEC_SCORE_EN.
module nw_path_decoder #(
   parameter int LENGTH      = 10,
   parameter int CWIDTH      = 2,
   parameter int SWIDTH      = 16,
   parameter int CORD_LENGTH = 8,
   parameter int MATCH       = 1,
   parameter int MISMATCH    = -1,
   parameter int INDEL       = -1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clear,
   input  logic [LENGTH*CWIDTH-1:0] s1,
   input  logic [LENGTH*CWIDTH-1:0] s2,
   nw_path_decoder_if.slave         bus,
   output logic                     done,
   output logic                     error
`ifdef NW_DEC_SCORE_EN
   ,
   output logic signed [SWIDTH-1:0] score,
   output logic                     score_valid
`endif
);
   localparam int CL    = CORD_LENGTH;
   localparam int DEPTH = 2*LENGTH-1;
   localparam int SPW   = $clog2(DEPTH+1);
   localparam int EW    = 2 + 2*CL;

   if (LENGTH < 2 || LENGTH > 2**CL || SWIDTH < 2 ||
       MATCH >= 2**(SWIDTH-1) || MISMATCH < -(2**(SWIDTH-1)) ||
       INDEL < -(2**(SWIDTH-1))) begin : g_bad_cfg
      $error("nw_path_decoder: unsupported parameter set");
   end

   typedef enum logic [2:0] {
      S_INGEST, S_FLUSH, S_EMIT, S_DONE, S_ERR
   } state_t;

   state_t              r_state;
   logic [EW-1:0]       r_stack [DEPTH];
   logic [SPW-1:0]      r_sp;
   logic                r_pend;
   logic [CL-1:0]       r_px;
   logic [CL-1:0]       r_py;
   logic                r_ov;
   logic [1:0]          r_op;
   logic [CWIDTH-1:0]   r_c1;
   logic [CWIDTH-1:0]   r_c2;
   logic                r_match;
   logic                r_last;

   function automatic logic [CWIDTH-1:0] ch(
      input logic [LENGTH*CWIDTH-1:0] s,
      input logic [CL-1:0]            i
   );
      logic [LENGTH*CWIDTH-1:0] t;
      t = s >> (CWIDTH * (LENGTH - 1 - int'(i)));
      return t[CWIDTH-1:0];
   endfunction

   logic [CL-1:0] w_x, w_y, w_dx, w_dy;
   logic          w_acc, w_range, w_first, w_zero, w_full;
   logic          w_diag, w_up, w_left, w_bad;
   logic [1:0]    w_op;

   assign w_x     = bus.in_data[2*CL-1:CL];
   assign w_y     = bus.in_data[CL-1:0];
   assign w_acc   = bus.in_valid && bus.in_ready;
   // Deltas wrap at coordinate width, so stepping left of 0 never classifies
   assign w_dx    = r_px - 1'b1;
   assign w_dy    = r_py - 1'b1;
   assign w_range = ({1'b0, w_x} < (CL+1)'(LENGTH)) &&
                    ({1'b0, w_y} < (CL+1)'(LENGTH));
   assign w_first = (w_x == CL'(LENGTH-1)) && (w_y == CL'(LENGTH-1));
   assign w_zero  = (w_x == '0) && (w_y == '0);
   assign w_full  = (r_sp == SPW'(DEPTH));
   assign w_diag  = (w_x == w_dx) && (w_y == w_dy);
   assign w_up    = (w_x == r_px) && (w_y == w_dy);
   assign w_left  = (w_x == w_dx) && (w_y == r_py);

   always_comb begin
      w_op  = 2'b00;
      w_bad = 1'b0;
      unique case (1'b1)
         w_diag:  w_op = 2'b10;
         w_up:    w_op = 2'b00;
         w_left:  w_op = 2'b01;
         default: w_bad = 1'b1;
      endcase
   end

   // First load reads the top; a pop reloads from the entry beneath it
   logic [SPW-1:0]    w_idx;
   logic [EW-1:0]     w_sel;
   logic [1:0]        w_eop;
   logic [CL-1:0]     w_ex, w_ey;
   logic [CWIDTH-1:0] w_ch1, w_ch2;

   assign w_idx = r_ov ? r_sp - SPW'(2) : r_sp - SPW'(1);
   assign w_sel = r_stack[w_idx];
   assign w_eop = w_sel[EW-1:EW-2];
   assign w_ex  = w_sel[2*CL-1:CL];
   assign w_ey  = w_sel[CL-1:0];
   assign w_ch1 = ch(s1, w_ey);
   assign w_ch2 = ch(s2, w_ex);

`ifdef NW_DEC_SCORE_EN
   logic signed [SWIDTH-1:0] r_score;
   logic signed [SWIDTH-1:0] w_wt;
   assign w_wt = (r_op == 2'b10) ?
                 (r_match ? SWIDTH'(MATCH) : SWIDTH'(MISMATCH)) :
                 SWIDTH'(INDEL);
   assign score       = r_score;
   assign score_valid = (r_state == S_DONE);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_INGEST;
         r_sp    <= '0;
         r_pend  <= 1'b0;
         r_px    <= '0;
         r_py    <= '0;
         r_ov    <= 1'b0;
         r_op    <= '0;
         r_c1    <= '0;
         r_c2    <= '0;
         r_match <= 1'b0;
         r_last  <= 1'b0;
         for (int k = 0; k < DEPTH; k++) r_stack[k] <= '0;
`ifdef NW_DEC_SCORE_EN
         r_score <= '0;
`endif
      end else begin
         unique case (r_state)
            S_INGEST: begin
               if (w_acc) begin
                  if (!w_range) begin
                     r_state <= S_ERR;
                  end else if (!r_pend) begin
                     if (w_first) begin
                        r_px   <= w_x;
                        r_py   <= w_y;
                        r_pend <= 1'b1;
                     end else begin
                        r_state <= S_ERR;
                     end
                  end else if (w_bad || w_full) begin
                     r_state <= S_ERR;
                  end else begin
                     r_stack[r_sp] <= {w_op, r_px, r_py};
                     r_sp          <= r_sp + SPW'(1);
                     r_px          <= w_x;
                     r_py          <= w_y;
                     if (w_zero) r_state <= S_FLUSH;
                  end
               end
            end
            S_FLUSH: begin
               if (w_full) begin
                  r_state <= S_ERR;
               end else begin
                  r_stack[r_sp] <= {2'b10, r_px, r_py};
                  r_sp          <= r_sp + SPW'(1);
                  r_state       <= S_EMIT;
               end
            end
            S_EMIT: begin
               if (!r_ov || bus.out_ready) begin
`ifdef NW_DEC_SCORE_EN
                  if (r_ov) r_score <= r_score + w_wt;
`endif
                  if (r_ov && r_sp == SPW'(1)) begin
                     r_sp    <= '0;
                     r_ov    <= 1'b0;
                     r_op    <= '0;
                     r_c1    <= '0;
                     r_c2    <= '0;
                     r_match <= 1'b0;
                     r_last  <= 1'b0;
                     r_state <= S_DONE;
                  end else begin
                     if (r_ov) r_sp <= r_sp - SPW'(1);
                     r_ov    <= 1'b1;
                     r_op    <= w_eop;
                     r_c1    <= (w_eop == 2'b01) ? '0 : w_ch1;
                     r_c2    <= (w_eop == 2'b00) ? '0 : w_ch2;
                     r_match <= (w_eop == 2'b10) && (w_ch1 == w_ch2);
                     r_last  <= r_ov ? (r_sp == SPW'(2)) : (r_sp == SPW'(1));
                  end
               end
            end
            S_DONE, S_ERR: begin
               if (clear) begin
                  r_state <= S_INGEST;
                  r_sp    <= '0;
                  r_pend  <= 1'b0;
`ifdef NW_DEC_SCORE_EN
                  r_score <= '0;
`endif
               end
            end
            default: r_state <= S_ERR;
         endcase
      end
   end

   assign bus.in_ready  = (r_state == S_INGEST) && !reset;
   assign bus.out_valid = r_ov;
   assign bus.out_op    = r_op;
   assign bus.out_c1    = r_c1;
   assign bus.out_c2    = r_c2;
   assign bus.out_match = r_match;
   assign bus.out_last  = r_last;
   assign done          = (r_state == S_DONE);
   assign error         = (r_state == S_ERR);
endmodule

// File: tb/tb_nw_path_decoder.sv
// Directed bench for nw_path_decoder at LENGTH=4: path table plus
// hand-written error, backpressure and reset sequences.
module tb_nw_path_decoder;
   localparam int L  = 4;
   localparam int CW = 2;
   localparam int CL = 8;
   localparam int SW = 16;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            clear = 1'b0;
   logic [L*CW-1:0] s1 = '0;
   logic [L*CW-1:0] s2 = '0;
   logic            done, error;
`ifdef NW_DEC_SCORE_EN
   logic signed [SW-1:0] score;
   logic                 score_valid;
`endif

   nw_path_decoder_if #(.CWIDTH(CW), .CORD_LENGTH(CL)) bus ();

   nw_path_decoder #(
      .LENGTH(L), .CWIDTH(CW), .SWIDTH(SW), .CORD_LENGTH(CL)
   ) dut (
      .clk(clk),
      .reset(reset),
      .clear(clear),
      .s1(s1),
      .s2(s2),
      .bus(bus.slave),
      .done(done),
      .error(error)
`ifdef NW_DEC_SCORE_EN
      ,
      .score(score),
      .score_valid(score_valid)
`endif
   );

   always #5 clk = ~clk;

   // col byte = {op, c1, c2, match, last}
   typedef struct {
      logic [7:0]  s1;
      logic [7:0]  s2;
      int          nw;
      logic [15:0] w [7];
      int          nc;
      logic [7:0]  col [7];
      int          score;
   } vec_t;

   vec_t tv [4];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic logic [7:0] col();
      return {bus.out_op, bus.out_c1, bus.out_c2, bus.out_match, bus.out_last};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input logic [15:0] w);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      step();
      bus.in_valid = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic run_vec(input int i, input bit bp);
      int lat;
      int k;
      int cyc;
      s1 = tv[i].s1;
      s2 = tv[i].s2;
      bus.out_ready = 1'b0;
      for (int j = 0; j < tv[i].nw; j++) feed(tv[i].w[j]);
      lat = 0;
      while (!bus.out_valid && lat < 10) begin
         step();
         lat++;
      end
      chk($sformatf("v%0d latency", i), lat, 2);
      k = 0;
      cyc = 0;
      while (k < tv[i].nc && cyc < 100) begin
         if (bus.out_valid)
            chk($sformatf("v%0d col%0d", i, k), col(), tv[i].col[k]);
         bus.out_ready = bp ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
         if (bus.out_valid && bus.out_ready) k++;
         step();
         cyc++;
      end
      chk($sformatf("v%0d columns", i), k, tv[i].nc);
      chk($sformatf("v%0d valid_end", i), bus.out_valid, 0);
      chk($sformatf("v%0d done", i), done, 1);
`ifdef NW_DEC_SCORE_EN
      chk($sformatf("v%0d score", i), score, 16'(tv[i].score));
      chk($sformatf("v%0d score_valid", i), score_valid, 1);
`endif
      bus.out_ready = 1'b0;
      pulse_clear();
      chk($sformatf("v%0d done_clr", i), done, 0);
      chk($sformatf("v%0d ready_clr", i), bus.in_ready, 1);
   endtask

   initial begin
      int nv;
      tv[0] = '{s1: 8'h1B, s2: 8'h1B, nw: 4,
                w: '{16'h0303, 16'h0202, 16'h0101, 16'h0000, 0, 0, 0},
                nc: 4,
                col: '{8'h82, 8'h96, 8'hAA, 8'hBF, 0, 0, 0},
                score: 4};
      tv[1] = '{s1: 8'h1B, s2: 8'h1B, nw: 5,
                w: '{16'h0303, 16'h0302, 16'h0201, 16'h0100, 16'h0000, 0, 0},
                nc: 5,
                col: '{8'h82, 8'h44, 8'h98, 8'hAC, 8'h31, 0, 0},
                score: -3};
      tv[2] = '{s1: 8'hE4, s2: 8'h1B, nw: 6,
                w: '{16'h0303, 16'h0203, 16'h0103, 16'h0002, 16'h0001,
                     16'h0000, 0},
                nc: 6,
                col: '{8'hB0, 8'h20, 8'h10, 8'h84, 8'h48, 8'h4D, 0},
                score: -6};
      tv[3] = '{s1: 8'h1B, s2: 8'h1B, nw: 7,
                w: '{16'h0303, 16'h0302, 16'h0301, 16'h0300, 16'h0200,
                     16'h0100, 16'h0000},
                nc: 7,
                col: '{8'h82, 8'h44, 8'h48, 8'h4C, 8'h10, 8'h20, 8'h31},
                score: -5};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst in_ready", bus.in_ready, 0);
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst col", col(), 0);
      chk("rst done", done, 0);
      chk("rst error", error, 0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rel in_ready", bus.in_ready, 1);

      for (int i = 0; i < 4; i++) run_vec(i, 1'b0);

      // backpressure on the gap path
      run_vec(1, 1'b1);

      // bad first word
      feed(16'h0203);
      chk("first err", error, 1);
      chk("first in_ready", bus.in_ready, 0);
      chk("first out_valid", bus.out_valid, 0);
      pulse_clear();
      chk("first err_clr", error, 0);
      chk("first ready_clr", bus.in_ready, 1);
      run_vec(1, 1'b0);

      // illegal delta
      feed(16'h0303);
      feed(16'h0102);
      chk("delta err", error, 1);
      nv = 0;
      for (int c = 0; c < 5; c++) begin
         if (bus.out_valid) nv++;
         step();
      end
      chk("delta no_cols", nv, 0);
      pulse_clear();

      // reset mid-EMIT with two columns still stacked
      s1 = 8'h1B;
      s2 = 8'h1B;
      for (int j = 0; j < 4; j++) feed(tv[0].w[j]);
      bus.out_ready = 1'b1;
      nv = 0;
      while (!bus.out_valid && nv < 10) begin
         step();
         nv++;
      end
      step();
      step();
      chk("mid col", col(), 8'hAA);
      chk("mid valid", bus.out_valid, 1);
      reset = 1'b1;
      #1;
      chk("mid rst valid", bus.out_valid, 0);
      chk("mid rst col", col(), 0);
      chk("mid rst in_ready", bus.in_ready, 0);
      @(negedge clk);
      reset = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      chk("mid rel in_ready", bus.in_ready, 1);
      chk("mid rel done", done, 0);
      run_vec(0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
